pipe_cla_subtractor: RTL

//  Two-stage pipelined carry-lookahead subtractor: diff = a - b - bin (mod 2^SIZE), with borrow-out
//  and signed-overflow flags. Inverse-direction counterpart of the team's combinational CLA adder.

---
 rtl/pfx_pkg.sv | 20 ++
 rtl/cla_group_pg.sv | 32 +++
 rtl/pipe_cla_subtractor.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pfx_pkg.sv
// Shared definitions for the prefix/lookahead adder family: default widths,
// the per-bit / per-group generate-propagate pair, and a group-count helper.
package pfx_pkg;

  localparam int DEF_SIZE  = 16;
  localparam int DEF_GSIZE = 4;
  localparam int NGROUPS   = DEF_SIZE / DEF_GSIZE;

  // Generate/propagate pair for one bit or one lookahead group.
  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // Number of lookahead groups for a given operand and group width.
  function automatic int num_groups(input int size, input int gsize);
    return size / gsize;
  endfunction

endpackage

// File: rtl/cla_group_pg.sv
// Combinational group generate/propagate for one lookahead block.
// For GSIZE=4 this is G = g3|p3g2|p3p2g1|p3p2p1g0 and P = p3p2p1p0.
module cla_group_pg
  import pfx_pkg::*;
#(
  parameter int GSIZE = DEF_GSIZE
) (
  input  logic [GSIZE-1:0] i_g,
  input  logic [GSIZE-1:0] i_p,
  output pg_t              o_pg
);

  logic w_g_acc;
  logic w_p_acc;

  // Fold bits from LSB to MSB: a higher generate wins, otherwise a lower one
  // survives only if it propagates through every bit above it.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch or
    // loop so no path leaves it unassigned, which would infer a latch.
    w_g_acc = 1'b0;
    w_p_acc = 1'b1;
    for (int i = 0; i < GSIZE; i++) begin
      w_g_acc = i_g[i] | (i_p[i] & w_g_acc);
      w_p_acc = w_p_acc & i_p[i];
    end
  end

  assign o_pg.g = w_g_acc;
  assign o_pg.p = w_p_acc;

endmodule

// File: rtl/pipe_cla_subtractor.sv
// Two-stage pipelined carry-lookahead subtractor with valid/ready handshakes.
// diff = a - b - bin (mod 2^SIZE), computed as a + ~b + ~bin.
// Stage 1 registers bit and group generate/propagate; stage 2 resolves the
// group carries serially, expands them to bit carries and registers results.
module pipe_cla_subtractor
  import pfx_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int GSIZE = DEF_GSIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] diff,
  output logic            bout,
  output logic            ovf
);

  localparam int NG = num_groups(SIZE, GSIZE);

  // Operand width must split evenly into lookahead groups.
  if (SIZE % GSIZE != 0) begin : g_bad_size
    $error("pipe_cla_subtractor: SIZE must be a multiple of GSIZE");
  end

  // ---------------------------------------------------------------------------
  // Handshake: each stage advances when it is empty or the stage below moves.
  // ---------------------------------------------------------------------------
  logic w_adv1;
  logic w_adv2;
  logic w_in_fire;

  logic r_s1_valid;
  logic r_s2_valid;

  assign w_adv2    = ~r_s2_valid | out_ready;
  assign w_adv1    = ~r_s1_valid | w_adv2;
  assign in_ready  = w_adv1;
  assign w_in_fire = in_valid & w_adv1;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: bit g/p of a + ~b, then group G/P per block.
  // ---------------------------------------------------------------------------
  logic [SIZE-1:0] w_nb;
  logic [SIZE-1:0] w_g;
  logic [SIZE-1:0] w_p;
  pg_t  [NG-1:0]   w_grp_pg;

  assign w_nb = ~b;
  assign w_g  = a & w_nb;
  assign w_p  = a ^ w_nb;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group_pg #(
      .GSIZE (GSIZE)
    ) u_grp (
      .i_g  (w_g[k*GSIZE +: GSIZE]),
      .i_p  (w_p[k*GSIZE +: GSIZE]),
      .o_pg (w_grp_pg[k])
    );
  end

  // Stage 1 registers.
  logic [SIZE-1:0] r_s1_g;
  logic [SIZE-1:0] r_s1_p;
  pg_t  [NG-1:0]   r_s1_grp_pg;
  logic            r_s1_c0;
  logic            r_s1_a_msb;
  logic            r_s1_b_msb;

  // Stage 1 valid: take a new operand on advance, otherwise drain to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state updates in clocked blocks use non-blocking assignment so
      // every register samples pre-edge values regardless of block order.
      r_s1_valid <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
    end
  end

  // Stage 1 data: loads only on an input transfer so idle or stalled inputs
  // never disturb the held operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too; this keeps X off the outputs
      // even if out_ready toggles before the first operand arrives.
      r_s1_g      <= '0;
      r_s1_p      <= '0;
      r_s1_grp_pg <= '0;
      r_s1_c0     <= 1'b0;
      r_s1_a_msb  <= 1'b0;
      r_s1_b_msb  <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_g      <= w_g;
      r_s1_p      <= w_p;
      r_s1_grp_pg <= w_grp_pg;
      r_s1_c0     <= ~bin;
      r_s1_a_msb  <= a[SIZE-1];
      r_s1_b_msb  <= b[SIZE-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: serial group carries, bit carries within groups.
  // ---------------------------------------------------------------------------
  logic [SIZE-1:0] w_bit_c;
  logic            w_carry_out;
  logic [SIZE-1:0] w_diff;
  logic            w_ovf;

  // Group carry C_k = G_k | P_k & C_{k-1}; each group expands its incoming
  // carry into per-bit carries from its own bit g/p.
  always_comb begin
    logic c_grp;
    logic c_bit;
    w_bit_c = '0;
    c_grp   = r_s1_c0;
    c_bit   = 1'b0;
    for (int k = 0; k < NG; k++) begin
      c_bit = c_grp;
      for (int j = 0; j < GSIZE; j++) begin
        w_bit_c[k*GSIZE + j] = c_bit;
        c_bit = r_s1_g[k*GSIZE + j] | (r_s1_p[k*GSIZE + j] & c_bit);
      end
      c_grp = r_s1_grp_pg[k].g | (r_s1_grp_pg[k].p & c_grp);
    end
    w_carry_out = c_grp;
  end

  assign w_diff = r_s1_p ^ w_bit_c;
  assign w_ovf  = (r_s1_a_msb ^ r_s1_b_msb) & (w_diff[SIZE-1] ^ r_s1_a_msb);

  // Stage 2 registers.
  logic [SIZE-1:0] r_diff;
  logic            r_bout;
  logic            r_ovf;

  // Stage 2 valid: follows stage 1 on advance, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
    end
  end

  // Stage 2 results: load only when stage 1 hands over valid data, so the
  // outputs stay bit-stable through back-pressure. A missing carry out of
  // a + ~b + ~bin means the subtraction borrowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_adv2 && r_s1_valid) begin
      r_diff <= w_diff;
      r_bout <= ~w_carry_out;
      r_ovf  <= w_ovf;
    end
  end

  assign out_valid = r_s2_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

endmodule
